// File: rtl/saturn_bus_xfer_if.sv
// saturn_bus_xfer_if
// Groups the request/response handshake of the multi-nibble transfer engine
// together with its hp48 nibble-bus command side.
//   req_*          : request from the instruction decoder (valid/ready)
//   bus_command/bus_address/bus_nibble_in/bus_strobe : to the bus controller
//   bus_nibble_out/bus_error                         : from the bus controller
//   done/err/rdata/next_addr                         : completion result
// Handshake: a request transfers on a clk edge where req_valid and req_ready
// are both high; req_valid may be raised at any time and req_ready does not
// depend on req_valid. done is a one-cycle pulse; err/rdata/next_addr are
// valid with it and hold until the next accepted request.
// Modports: slave = the transfer engine, master = its environment
// (decoder plus bus controller, or a testbench).
interface saturn_bus_xfer_if #(
  parameter int DATA_NIBBLES = 16,
  parameter int ADDR_W       = 20,
  parameter int CNT_W        = 5
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic                      req_pc_mode;
  logic [ADDR_W-1:0]         req_addr;
  logic [CNT_W-1:0]          req_count;
  logic [CNT_W-1:0]          req_offset;
  logic [4*DATA_NIBBLES-1:0] req_wdata;

  logic [3:0]                bus_command;
  logic [ADDR_W-1:0]         bus_address;
  logic [3:0]                bus_nibble_in;
  logic                      bus_strobe;
  logic [3:0]                bus_nibble_out;
  logic                      bus_error;

  logic                      done;
  logic                      err;
  logic [4*DATA_NIBBLES-1:0] rdata;
  logic [ADDR_W-1:0]         next_addr;

  modport slave (
    input  req_valid, req_write, req_pc_mode, req_addr, req_count, req_offset,
           req_wdata, bus_nibble_out, bus_error,
    output req_ready, bus_command, bus_address, bus_nibble_in, bus_strobe,
           done, err, rdata, next_addr
  );

  modport master (
    output req_valid, req_write, req_pc_mode, req_addr, req_count, req_offset,
           req_wdata, bus_nibble_out, bus_error,
    input  req_ready, bus_command, bus_address, bus_nibble_in, bus_strobe,
           done, err, rdata, next_addr
  );
endinterface

// File: rtl/saturn_bus_xfer.sv
// saturn_bus_xfer
// Multi-nibble bus transfer engine. One accepted request becomes a
// load-address command followed by one read/write command per nibble on the
// hp48 nibble bus, each operation being a strobe cycle followed by a capture
// cycle. Read nibbles are merged into a DATA_NIBBLES-nibble register image
// starting at req_offset and wrapping at the top nibble.
// Ports:
//   clk       : system clock
//   reset     : synchronous, active-high; aborts any transfer without done
//   xfer      : saturn_bus_xfer_if.slave (request, bus and result signals)
//   dbg_state : current FSM state encoding, for observation only
module saturn_bus_xfer #(
  parameter int         DATA_NIBBLES = 16,
  parameter int         ADDR_W       = 20,
  parameter int         CNT_W        = 5,
  parameter logic [3:0] CMD_NOP      = 4'd0,
  parameter logic [3:0] CMD_PC_READ  = 4'd1,
  parameter logic [3:0] CMD_DP_READ  = 4'd2,
  parameter logic [3:0] CMD_DP_WRITE = 4'd3,
  parameter logic [3:0] CMD_LOAD_PC  = 4'd4,
  parameter logic [3:0] CMD_LOAD_DP  = 4'd5
) (
  input  logic             clk,
  input  logic             reset,
  saturn_bus_xfer_if.slave xfer,
  output logic [2:0]       dbg_state
);

  localparam int                DW       = 4 * DATA_NIBBLES;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DATA_NIBBLES);
  localparam logic [CNT_W-1:0]  POS_LAST = CNT_W'(DATA_NIBBLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_ISS = 3'd1,
    LOAD_CAP = 3'd2,
    NIB_ISS  = 3'd3,
    NIB_CAP  = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t state, state_n;

  // Latched request
  logic              wr_q, wr_n;
  logic              pc_q, pc_n;
  logic [ADDR_W-1:0] addr_q, addr_n;   // address of the next nibble
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [CNT_W-1:0]  idx_q, idx_n;     // transfer index i
  logic [CNT_W-1:0]  pos_q, pos_n;     // (offset + i) mod DATA_NIBBLES
  logic [DW-1:0]     wdata_q, wdata_n;

  // Next values of the registered outputs
  logic [3:0]        bus_command_n;
  logic [ADDR_W-1:0] bus_address_n;
  logic [3:0]        bus_nibble_in_n;
  logic              bus_strobe_n;
  logic              done_n;
  logic              err_n;
  logic [DW-1:0]     rdata_n;
  logic [ADDR_W-1:0] next_addr_n;

  logic              illegal;
  logic [3:0]        nib_cmd;
  logic [CNT_W-1:0]  pos_inc;

  function automatic logic [3:0] nib_of(input logic [DW-1:0] v,
                                        input logic [CNT_W-1:0] p);
    logic [3:0] r;
    r = 4'h0;
    for (int k = 0; k < DATA_NIBBLES; k++) begin
      if (p == CNT_W'(k)) r = v[k*4 +: 4];
    end
    return r;
  endfunction

  assign xfer.req_ready = (state == IDLE);
  assign dbg_state      = state;

  assign illegal = (xfer.req_count > CNT_MAX) || (xfer.req_offset >= CNT_MAX) ||
                   (xfer.req_pc_mode && xfer.req_write);
  assign nib_cmd = pc_q ? CMD_PC_READ : (wr_q ? CMD_DP_WRITE : CMD_DP_READ);
  assign pos_inc = (pos_q == POS_LAST) ? '0 : pos_q + CNT_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      wr_q               <= 1'b0;
      pc_q               <= 1'b0;
      addr_q             <= '0;
      cnt_q              <= '0;
      idx_q              <= '0;
      pos_q              <= '0;
      wdata_q            <= '0;
      xfer.bus_command   <= CMD_NOP;
      xfer.bus_address   <= '0;
      xfer.bus_nibble_in <= 4'h0;
      xfer.bus_strobe    <= 1'b0;
      xfer.done          <= 1'b0;
      xfer.err           <= 1'b0;
      xfer.rdata         <= '0;
      xfer.next_addr     <= '0;
    end else begin
      state              <= state_n;
      wr_q               <= wr_n;
      pc_q               <= pc_n;
      addr_q             <= addr_n;
      cnt_q              <= cnt_n;
      idx_q              <= idx_n;
      pos_q              <= pos_n;
      wdata_q            <= wdata_n;
      xfer.bus_command   <= bus_command_n;
      xfer.bus_address   <= bus_address_n;
      xfer.bus_nibble_in <= bus_nibble_in_n;
      xfer.bus_strobe    <= bus_strobe_n;
      xfer.done          <= done_n;
      xfer.err           <= err_n;
      xfer.rdata         <= rdata_n;
      xfer.next_addr     <= next_addr_n;
    end
  end

  // Outputs are registered, so each branch sets the output values that belong
  // to the state being entered.
  always_comb begin
    state_n         = state;
    wr_n            = wr_q;
    pc_n            = pc_q;
    addr_n          = addr_q;
    cnt_n           = cnt_q;
    idx_n           = idx_q;
    pos_n           = pos_q;
    wdata_n         = wdata_q;
    bus_command_n   = xfer.bus_command;
    bus_address_n   = xfer.bus_address;
    bus_nibble_in_n = xfer.bus_nibble_in;
    bus_strobe_n    = 1'b0;
    done_n          = 1'b0;
    err_n           = xfer.err;
    rdata_n         = xfer.rdata;
    next_addr_n     = xfer.next_addr;

    case (state)
      IDLE: begin
        if (xfer.req_valid) begin
          wr_n    = xfer.req_write;
          pc_n    = xfer.req_pc_mode;
          addr_n  = xfer.req_addr;
          cnt_n   = xfer.req_count;
          idx_n   = '0;
          pos_n   = xfer.req_offset;
          wdata_n = xfer.req_wdata;
          rdata_n = xfer.req_wdata;
          err_n   = 1'b0;
          if (illegal || (xfer.req_count == '0)) begin
            // Nothing goes on the bus; zero nibbles moved.
            state_n       = DONE;
            done_n        = 1'b1;
            err_n         = illegal;
            next_addr_n   = xfer.req_addr;
            bus_command_n = CMD_NOP;
          end else begin
            state_n       = LOAD_ISS;
            bus_command_n = xfer.req_pc_mode ? CMD_LOAD_PC : CMD_LOAD_DP;
            bus_address_n = xfer.req_addr;
            bus_strobe_n  = 1'b1;
          end
        end
      end

      LOAD_ISS: state_n = LOAD_CAP;

      LOAD_CAP: begin
        if (xfer.bus_error) begin
          state_n       = DONE;
          done_n        = 1'b1;
          err_n         = 1'b1;
          next_addr_n   = addr_q;
          bus_command_n = CMD_NOP;
        end else begin
          state_n       = NIB_ISS;
          bus_command_n = nib_cmd;
          bus_strobe_n  = 1'b1;
          if (wr_q) bus_nibble_in_n = nib_of(wdata_q, pos_q);
        end
      end

      NIB_ISS: state_n = NIB_CAP;

      NIB_CAP: begin
        if (xfer.bus_error) begin
          // Faulting nibble is dropped and does not count toward next_addr.
          state_n       = DONE;
          done_n        = 1'b1;
          err_n         = 1'b1;
          next_addr_n   = addr_q;
          bus_command_n = CMD_NOP;
        end else begin
          if (!wr_q) begin
            for (int k = 0; k < DATA_NIBBLES; k++) begin
              if (pos_q == CNT_W'(k)) rdata_n[k*4 +: 4] = xfer.bus_nibble_out;
            end
          end
          addr_n = addr_q + ADDR_ONE;
          if (idx_q == cnt_q - CNT_ONE) begin
            state_n       = DONE;
            done_n        = 1'b1;
            next_addr_n   = addr_q + ADDR_ONE;
            bus_command_n = CMD_NOP;
          end else begin
            state_n       = NIB_ISS;
            idx_n         = idx_q + CNT_ONE;
            pos_n         = pos_inc;
            bus_command_n = nib_cmd;
            bus_strobe_n  = 1'b1;
            if (wr_q) bus_nibble_in_n = nib_of(wdata_q, pos_inc);
          end
        end
      end

      DONE: state_n = IDLE;

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_saturn_bus_xfer.sv
`timescale 1ns/1ps
module tb_saturn_bus_xfer;
  localparam int N  = 16;
  localparam int AW = 20;
  localparam int CW = 5;
  localparam logic [3:0] C_NOP = 4'd0, C_PCR = 4'd1, C_DPR = 4'd2,
                         C_DPW = 4'd3, C_LPC = 4'd4, C_LDP = 4'd5;
  localparam logic [1:0] K_LOAD = 2'd0, K_READ = 2'd1, K_WRITE = 2'd2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] dbg_state;

  saturn_bus_xfer_if #(.DATA_NIBBLES(N), .ADDR_W(AW), .CNT_W(CW)) bif();

  saturn_bus_xfer #(.DATA_NIBBLES(N), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .xfer      (bif),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  // strobe record: {kind[1:0], cycle[7:0], command[3:0], value[19:0]}
  logic [33:0] exp_q[$];
  // result record: {err, next_addr[19:0], rdata[63:0]}
  logic [84:0] res_q[$];
  int          exp_done_cyc;
  logic [3:0]  rd_src[N];
  int          err_idx = -1;   // -1 none, -2 fault on load, else nibble index

  // ---------------- bus controller model ----------------
  int nib_i   = 0;
  bit bm_prev = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      bif.bus_nibble_out = 4'h0;
      bif.bus_error      = 1'b0;
      nib_i              = 0;
    end else if (bif.bus_strobe) begin
      if (bif.bus_command == C_LPC || bif.bus_command == C_LDP) begin
        nib_i         = 0;
        bif.bus_error = (err_idx == -2);
      end else begin
        bif.bus_nibble_out = (nib_i < N) ? rd_src[nib_i] : 4'h0;
        bif.bus_error      = (nib_i == err_idx);
        nib_i++;
      end
    end else if (!bm_prev) begin
      bif.bus_error = 1'b0;
    end
    bm_prev = bif.bus_strobe;
  end

  // ---------------- reference model ----------------
  task automatic model_xfer(input logic w, input logic pc, input logic [AW-1:0] addr,
                            input int cnt, input int off, input logic [63:0] wd);
    logic [63:0]   rd;
    logic [63:0]   t;
    logic [AW-1:0] na;
    logic          e;
    int            p;
    rd = wd;
    na = addr;
    e  = 1'b0;
    exp_q.delete();
    if (cnt > N || off >= N || (pc && w)) begin
      e = 1'b1;
      exp_done_cyc = 1;
    end else if (cnt == 0) begin
      exp_done_cyc = 1;
    end else begin
      exp_q.push_back({K_LOAD, 8'd1, (pc ? C_LPC : C_LDP), addr});
      if (err_idx == -2) begin
        e = 1'b1;
        exp_done_cyc = 3;
      end else begin
        exp_done_cyc = 3 + 2 * cnt;
        for (int i = 0; i < cnt; i++) begin
          p = (off + i) % N;
          t = wd >> (4 * p);
          exp_q.push_back({(w ? K_WRITE : K_READ), 8'(3 + 2 * i),
                           (pc ? C_PCR : (w ? C_DPW : C_DPR)),
                           (w ? {16'h0, t[3:0]} : 20'h0)});
          if (i == err_idx) begin
            e = 1'b1;
            exp_done_cyc = 5 + 2 * i;
            break;
          end
          if (!w) rd = (rd & ~(64'hF << (4 * p))) | ({60'h0, rd_src[i]} << (4 * p));
          na = na + 1'b1;
        end
      end
    end
    res_q.push_back({e, na, rd});
  endtask

  // ---------------- driver ----------------
  task automatic send_req(input logic w, input logic pc, input logic [AW-1:0] addr,
                          input int cnt, input int off, input logic [63:0] wd);
    model_xfer(w, pc, addr, cnt, off, wd);
    @(negedge clk);
    tests_run++;
    if (bif.req_ready !== 1'b1 || bif.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL accept_ready: ready=%b done=%b, required ready=1 done=0",
               bif.req_ready, bif.done);
    end
    bif.req_write   = w;
    bif.req_pc_mode = pc;
    bif.req_addr    = addr;
    bif.req_count   = CW'(cnt);
    bif.req_offset  = CW'(off);
    bif.req_wdata   = wd;
    bif.req_valid   = 1'b1;
    @(posedge clk);
    #1;
    // Scramble request fields: the engine must work from its latched copy.
    bif.req_valid   = 1'b0;
    bif.req_write   = 1'($urandom_range(0, 1));
    bif.req_pc_mode = 1'($urandom_range(0, 1));
    bif.req_addr    = AW'($urandom_range(0, 1048575));
    bif.req_count   = CW'($urandom_range(0, 31));
    bif.req_offset  = CW'($urandom_range(0, 31));
    bif.req_wdata   = {$urandom, $urandom};
  endtask

  // Walks the transfer cycle by cycle (cycle 1 = first cycle after acceptance),
  // popping the strobe scoreboard on each strobe and the result on done.
  task automatic run_check(input string name);
    logic [33:0] e;
    logic [33:0] act;
    logic [84:0] r;
    bit          seen;
    bit          prev_s;
    seen   = 1'b0;
    prev_s = 1'b0;
    for (int c = 1; c <= 80 && !seen; c++) begin
      @(negedge clk);
      if (bif.bus_strobe) begin
        tests_run++;
        if (exp_q.size() == 0 || prev_s) begin
          tests_failed++;
          $display("FAIL %s strobe: unexpected strobe at cycle %0d cmd=%h (back_to_back=%0b), required none",
                   name, c, bif.bus_command, prev_s);
        end else begin
          e   = exp_q.pop_front();
          act = {e[33:32], 8'(c), bif.bus_command,
                 (e[33:32] == K_LOAD)  ? bif.bus_address :
                 (e[33:32] == K_WRITE) ? {16'h0, bif.bus_nibble_in} : 20'h0};
          if (act !== e) begin
            tests_failed++;
            $display("FAIL %s strobe: got {kind,cyc,cmd,val}=%h required %h", name, act, e);
          end
        end
      end
      prev_s = bif.bus_strobe;
      if (bif.done) begin
        seen = 1'b1;
        tests_run++;
        if (c != exp_done_cyc || exp_q.size() != 0 || bif.bus_command !== C_NOP ||
            bif.req_ready !== 1'b0) begin
          tests_failed++;
          $display("FAIL %s done: cycle=%0d pending=%0d cmd=%h ready=%b, required cycle=%0d pending=0 cmd=0 ready=0",
                   name, c, exp_q.size(), bif.bus_command, bif.req_ready, exp_done_cyc);
        end
        r = res_q.pop_front();
        tests_run++;
        if ({bif.err, bif.next_addr, bif.rdata} !== r) begin
          tests_failed++;
          $display("FAIL %s result: err=%b next=%h rdata=%h, required err=%b next=%h rdata=%h",
                   name, bif.err, bif.next_addr, bif.rdata, r[84], r[83:64], r[63:0]);
        end
      end
    end
    if (!seen) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s timeout: no done within 80 cycles, required done at cycle %0d",
               name, exp_done_cyc);
      exp_q.delete();
      res_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset           = 1'b1;
    bif.req_valid   = 1'b0;
    bif.req_write   = 1'b0;
    bif.req_pc_mode = 1'b0;
    bif.req_addr    = '0;
    bif.req_count   = '0;
    bif.req_offset  = '0;
    bif.req_wdata   = '0;
    for (int i = 0; i < N; i++) rd_src[i] = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({bif.bus_command, bif.bus_address, bif.bus_nibble_in, bif.bus_strobe, bif.done,
         bif.err, bif.rdata, bif.next_addr} !== '0 || bif.req_ready !== 1'b1 || dbg_state !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_values: cmd=%h addr=%h nib=%h stb=%b done=%b err=%b rdata=%h next=%h ready=%b state=%0d, required all zero ready=1 state=0",
               bif.bus_command, bif.bus_address, bif.bus_nibble_in, bif.bus_strobe, bif.done,
               bif.err, bif.rdata, bif.next_addr, bif.req_ready, dbg_state);
    end
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bif.req_ready !== 1'b1 || bif.bus_strobe !== 1'b0 || bif.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: ready=%b stb=%b done=%b, required 1 0 0",
               bif.req_ready, bif.bus_strobe, bif.done);
    end
  endtask

  task automatic test_dp_read();
    for (int i = 0; i < 5; i++) rd_src[i] = 4'(i + 1);
    err_idx = -1;
    send_req(1'b0, 1'b0, 20'h12345, 5, 0, {16{4'hF}});
    run_check("dp_read");
    tests_run++;
    if (bif.rdata !== 64'hFFFFFFFFFFF54321 || bif.next_addr !== 20'h1234A || bif.err !== 1'b0) begin
      tests_failed++;
      $display("FAIL dp_read_literal: rdata=%h next=%h err=%b, required FFFFFFFFFFF54321 1234A 0",
               bif.rdata, bif.next_addr, bif.err);
    end
  endtask

  task automatic test_dp_write();
    err_idx = -1;
    send_req(1'b1, 1'b0, 20'hFFFFE, 4, 14, 64'hBA000000000000DC);
    run_check("dp_write_wrap");
    tests_run++;
    if (bif.next_addr !== 20'h00002 || bif.rdata !== 64'hBA000000000000DC) begin
      tests_failed++;
      $display("FAIL dp_write_literal: next=%h rdata=%h, required 00002 BA000000000000DC",
               bif.next_addr, bif.rdata);
    end
  endtask

  task automatic test_bus_error();
    logic [63:0]   wd;
    logic [AW-1:0] a;
    for (int i = 0; i < N; i++) rd_src[i] = 4'($urandom_range(0, 15));
    wd      = {$urandom, $urandom};
    a       = AW'($urandom_range(0, 1048575));
    err_idx = 2;
    send_req(1'b0, 1'b0, a, 6, 0, wd);
    run_check("nib_error");
    tests_run++;
    if (bif.err !== 1'b1 || bif.next_addr !== a + 20'd2 || bif.rdata[63:8] !== wd[63:8] ||
        bif.rdata[7:0] !== {rd_src[1], rd_src[0]}) begin
      tests_failed++;
      $display("FAIL nib_error_literal: err=%b next=%h rdata=%h, required err=1 next=%h rdata=%h",
               bif.err, bif.next_addr, bif.rdata, a + 20'd2, {wd[63:8], rd_src[1], rd_src[0]});
    end
    err_idx = -2;
    send_req(1'b0, 1'b1, a, 3, 5, wd);
    run_check("load_error");
    err_idx = 4;
    send_req(1'b1, 1'b0, a, 9, 10, wd);
    run_check("write_error");
    err_idx = -1;
  endtask

  task automatic test_illegal();
    // {write, pc, count, offset, expected err}
    int tbl[5][5] = '{'{0, 0, 0, 3, 0}, '{0, 0, 17, 0, 1}, '{1, 1, 2, 0, 1},
                      '{0, 0, 4, 16, 1}, '{1, 0, 0, 15, 0}};
    logic [63:0] wd;
    err_idx = -1;
    for (int k = 0; k < 5; k++) begin
      wd = {$urandom, $urandom};
      send_req(1'(tbl[k][0]), 1'(tbl[k][1]), 20'hABCDE, tbl[k][2], tbl[k][3], wd);
      run_check("no_bus_request");
      tests_run++;
      if (bif.err !== 1'(tbl[k][4])) begin
        tests_failed++;
        $display("FAIL no_bus_err[%0d]: err=%b, required %0d", k, bif.err, tbl[k][4]);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [63:0] wd;
    bit          bad;
    wd      = {$urandom, $urandom};
    err_idx = -1;
    send_req(1'b1, 1'b0, 20'h00100, 8, 3, wd);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 5) begin
        tests_run++;
        if (bif.bus_strobe !== 1'b1 || bif.bus_command !== C_DPW || bif.bus_nibble_in !== wd[19:16]) begin
          tests_failed++;
          $display("FAIL abort_pre: stb=%b cmd=%h nib=%h, required 1 3 %h",
                   bif.bus_strobe, bif.bus_command, bif.bus_nibble_in, wd[19:16]);
        end
      end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if (dbg_state !== 3'd0 || bif.bus_command !== C_NOP || bif.bus_strobe !== 1'b0 ||
        bif.req_ready !== 1'b1 || bif.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_idle: state=%0d cmd=%h stb=%b ready=%b done=%b, required 0 0 0 1 0",
               dbg_state, bif.bus_command, bif.bus_strobe, bif.req_ready, bif.done);
    end
    exp_q.delete();
    res_q.delete();
    bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bif.done !== 1'b0 || bif.bus_strobe !== 1'b0) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL abort_quiet: done or strobe seen after reset abort, required none");
    end
  endtask

  task automatic test_pc_read();
    for (int i = 0; i < N; i++) rd_src[i] = 4'($urandom_range(0, 15));
    err_idx = -1;
    send_req(1'b0, 1'b1, AW'($urandom_range(0, 1048575)), 3, 15, {$urandom, $urandom});
    run_check("pc_read_wrap");
  endtask

  task automatic test_back_to_back();
    logic w;
    logic pc;
    err_idx = -1;
    for (int i = 0; i < N; i++) rd_src[i] = 4'($urandom_range(0, 15));
    send_req(1'b0, 1'b1, 20'h0F00F, 3, 0, {$urandom, $urandom});
    run_check("b2b_first");
    send_req(1'b0, 1'b1, 20'hFFFFF, 3, 14, {$urandom, $urandom});
    run_check("b2b_second");
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) rd_src[i] = 4'($urandom_range(0, 15));
      w  = 1'($urandom_range(0, 1));
      pc = w ? 1'b0 : 1'($urandom_range(0, 1));
      send_req(w, pc, AW'($urandom_range(0, 1048575)), $urandom_range(1, 16),
               $urandom_range(0, 15), {$urandom, $urandom});
      run_check("b2b_random");
    end
  endtask

  initial begin
    test_reset();
    test_dp_read();
    test_dp_write();
    test_bus_error();
    test_illegal();
    test_reset_abort();
    test_pc_read();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/saturn_bus_xfer.md
Name: saturn_bus_xfer

Overview:
Parametrised multi-nibble bus transfer engine that replaces the core's one-nibble-per-decode bus sequencing. It accepts one request (address, nibble count, start nibble, direction, pointer mode) and issues a load-address command, then one read/write command per nibble, on the hp48 nibble bus. Each bus operation uses a two-cycle strobe/capture scheme. Read nibbles are packed into a register image of DATA_NIBBLES nibbles with wrap-around placement. The block sits between the instruction decoder and the hp48 bus controller.

Parameters:
DATA_NIBBLES, 16, register image width in nibbles (64-bit register = 16)
ADDR_W, 20, bus address width
CNT_W, 5, width of req_count and req_offset; must hold DATA_NIBBLES
CMD_NOP / CMD_PC_READ / CMD_DP_READ / CMD_DP_WRITE / CMD_LOAD_PC / CMD_LOAD_DP, 0/1/2/3/4/5, 4-bit bus command encodings; override to match the shared bus command definitions

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  high when IDLE; request accepted on a clk edge where req_valid and req_ready are both high
req_write  in  1  1 = write memory, 0 = read memory
req_pc_mode  in  1  1 = PC fetch (LOAD_PC/PC_READ), 0 = data pointer (LOAD_DP/DP_READ/DP_WRITE)
req_addr  in  ADDR_W  start address
req_count  in  CNT_W  nibbles to transfer, 0..DATA_NIBBLES
req_offset  in  CNT_W  register nibble index of the first nibble, 0..DATA_NIBBLES-1
req_wdata  in  4*DATA_NIBBLES  write source; also the merge base for reads
bus_command  out  4  command to bus controller
bus_address  out  ADDR_W  address for load commands
bus_nibble_in  out  4  write nibble to the bus
bus_strobe  out  1  one-cycle pulse per bus operation
bus_nibble_out  in  4  read nibble from the bus
bus_error  in  1  bus fault
done  out  1  one-cycle completion pulse
err  out  1  valid with done
rdata  out  4*DATA_NIBBLES  merged read result; valid with done
next_addr  out  ADDR_W  req_addr + nibbles successfully transferred, mod 2^ADDR_W; valid with done

Behaviour:
- States: IDLE, LOAD_ISS, LOAD_CAP, NIB_ISS, NIB_CAP, DONE. All outputs are registered except req_ready, which is (state==IDLE).
- Reset values: state IDLE, bus_command CMD_NOP, bus_address 0, bus_nibble_in 0, bus_strobe 0, done 0, err 0, rdata 0, next_addr 0.
- Reset during any state aborts the transfer. The next cycle is IDLE and no done pulse is produced.
- Accept: request fields are latched into internal registers, and rdata is loaded with req_wdata. Changes on req_* inputs after acceptance are ignored.
- Illegal request: req_count > DATA_NIBBLES, req_offset >= DATA_NIBBLES, or req_pc_mode & req_write. The block goes straight to DONE with err=1 and issues no strobe.
- req_count == 0: goes straight to DONE with err=0, next_addr = req_addr, and no strobe.
- LOAD_ISS: bus_command = LOAD_PC or LOAD_DP, bus_address = req_addr, bus_strobe = 1. LOAD_CAP: bus_strobe = 0, bus_command held.
- NIB_ISS for transfer index i:
  - bus_command = PC_READ, DP_READ or DP_WRITE; bus_strobe = 1.
  - For writes, bus_nibble_in = req_wdata nibble at (offset+i) mod DATA_NIBBLES.
- NIB_CAP:
  - Reads sample bus_nibble_out into rdata nibble (offset+i) mod DATA_NIBBLES.
  - The internal address increments mod 2^ADDR_W.
  - If i == count-1, go to DONE; otherwise go to NIB_ISS with i+1.
- bus_error sampled high in LOAD_CAP or NIB_CAP:
  - Go to DONE with err=1. The faulting nibble is not stored and does not advance next_addr.
  - Earlier nibbles remain in rdata; nibbles never transferred keep their req_wdata value.
- DONE: done=1 for exactly one cycle, then IDLE. err, rdata and next_addr hold until the next acceptance.
- Latency, with the acceptance edge as cycle 0:
  - LOAD_ISS is cycle 1. Nibble i issues at cycle 3+2i and captures at cycle 4+2i.
  - done is high at cycle 3+2*count; req_ready returns at cycle 4+2*count.
  - Illegal or zero-count requests give done at cycle 1.
- bus_strobe is never high in two consecutive cycles.
- Between operations, bus_command holds its last value; it returns to CMD_NOP in DONE.

Test Plan:
1. DP read, addr 0x12345, count 5, offset 0, wdata all 0xF; bus returns 1,2,3,4,5 -> strobes at cycles 1,3,5,7,9,11; commands LOAD_DP then 5× DP_READ; done at 13; rdata = 0xFFFFFFFFFFF54321; next_addr 0x1234A; err 0.
2. DP write, addr 0xFFFFE, offset 14, count 4, wdata nibble14=A, 15=B, 0=C, 1=D -> bus_nibble_in sequence A,B,C,D on DP_WRITE strobes; next_addr 0x00002; done at 11.
3. 6-nibble read with bus_error raised at the capture of nibble 2 (cycle 8) -> done at 9 with err=1; rdata nibbles 0,1 updated and the rest equal wdata; next_addr = addr+2.
4. count 0 -> done at cycle 1, err 0, no strobe. count 17 -> done at cycle 1, err 1, no strobe. req_pc_mode=1 with write -> err 1, no strobe.
5. Reset asserted at cycle 6 of an 8-nibble write -> next cycle IDLE, bus_command NOP, bus_strobe 0, req_ready 1; no done pulse ever appears.
6. PC read, count 3 -> LOAD_PC then 3× PC_READ; two back-to-back requests accepted at cycles 0 and 10 both complete correctly with no overlapping strobes.
